// File: rtl/vga_bounce_sprites_if.sv
// vga_bounce_sprites_if: sync-generator inputs, speed controls and render/status outputs of the sprite engine.
interface vga_bounce_sprites_if #(
  parameter int NUM_SPRITES = 2,
  parameter int SPEED_W     = 4,
  parameter int COORD_W     = 10
);
  logic                           frame_tick;
  logic                           freeze;
  logic                           video_active;
  logic [COORD_W-1:0]             pix_x;
  logic [COORD_W-1:0]             pix_y;
  logic [NUM_SPRITES*SPEED_W-1:0] speed_x;
  logic [NUM_SPRITES*SPEED_W-1:0] speed_y;
  logic [5:0]                     rgb;
  logic                           overlap;
  logic [7:0]                     bounce_count;
  logic                           busy;
  modport master (
    output frame_tick, freeze, video_active, pix_x, pix_y, speed_x, speed_y,
    input  rgb, overlap, bounce_count, busy
  );
  modport slave (
    input  frame_tick, freeze, video_active, pix_x, pix_y, speed_x, speed_y,
    output rgb, overlap, bounce_count, busy
  );
endinterface

// File: rtl/vga_bounce_sprites.sv
// vga_bounce_sprites: N bouncing squares updated one per cycle after frame_tick, rendered into registered RGB.
module vga_bounce_sprites #(
  parameter int NUM_SPRITES  = 2,
  parameter int SPRITE_SIZE  = 50,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BORDER_WIDTH = 2,
  parameter int SPEED_W      = 4,
  parameter int COORD_W      = 10
) (
  input logic clk,
  input logic rst_n,
  vga_bounce_sprites_if.slave bus
);
  localparam int CW1 = COORD_W + 1;
  localparam int IW  = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
  localparam logic [5:0] PALETTE [4] = '{6'b100100, 6'b001111, 6'b110011, 6'b111100};
  typedef enum logic {IDLE, UPDATE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [COORD_W-1:0] xs [NUM_SPRITES];
  logic [COORD_W-1:0] ys [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] dx, dy, hit;
  logic [COORD_W:0] nx, ny;
  logic [8:0] bsum;
  logic [7:0] bounce_q;
  logic [5:0] rgb_q, spr_rgb;
  logic overlap_q, acc, border, hit_multi;
  // Returns {flip, new_pos}; a blocked move flips direction and holds position
  function automatic logic [COORD_W:0] step_axis(input logic [COORD_W-1:0] pos, input logic dir,
                                                 input logic [SPEED_W-1:0] spd, input int limit);
    logic [COORD_W:0] sum;
    sum = CW1'(pos) + CW1'(SPRITE_SIZE) + CW1'(spd);
    step_axis = spd == '0 ? {1'b0, pos} :
                !dir ? (sum <= CW1'(limit) ? {1'b0, pos + COORD_W'(spd)} : {1'b1, pos}) :
                (pos >= COORD_W'(spd) ? {1'b0, pos - COORD_W'(spd)} : {1'b1, pos});
  endfunction
  assign nx = step_axis(xs[idx], dx[idx], bus.speed_x[idx*SPEED_W +: SPEED_W], H_ACTIVE);
  assign ny = step_axis(ys[idx], dy[idx], bus.speed_y[idx*SPEED_W +: SPEED_W], V_ACTIVE);
  assign bsum = {1'b0, bounce_q} + 9'(nx[COORD_W]) + 9'(ny[COORD_W]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? ((bus.frame_tick && !bus.freeze) ? UPDATE : IDLE)
                             : (idx == IW'(NUM_SPRITES - 1) ? IDLE : UPDATE);
  always_comb bus.busy = state == UPDATE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      dx <= '0;
      dy <= '0;
      bounce_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        xs[i] <= COORD_W'(i * SPRITE_SIZE);
        ys[i] <= '0;
      end
    end else begin
      idx <= state == UPDATE ? idx + IW'(1) : '0;
      if (state == UPDATE) begin
        xs[idx] <= nx[COORD_W-1:0];
        ys[idx] <= ny[COORD_W-1:0];
        dx[idx] <= dx[idx] ^ nx[COORD_W];
        dy[idx] <= dy[idx] ^ ny[COORD_W];
        bounce_q <= bsum[8] ? 8'hff : bsum[7:0];
      end
    end
  always_comb begin
    hit = '0;
    spr_rgb = '0;
    for (int i = 0; i < NUM_SPRITES; i++)
      hit[i] = bus.pix_x >= xs[i] && CW1'(bus.pix_x) < CW1'(xs[i]) + CW1'(SPRITE_SIZE) &&
               bus.pix_y >= ys[i] && CW1'(bus.pix_y) < CW1'(ys[i]) + CW1'(SPRITE_SIZE);
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      spr_rgb = hit[i] ? PALETTE[i] : spr_rgb;
  end
  assign border = bus.pix_x < COORD_W'(BORDER_WIDTH) || bus.pix_x >= COORD_W'(H_ACTIVE - BORDER_WIDTH) ||
                  bus.pix_y < COORD_W'(BORDER_WIDTH) || bus.pix_y >= COORD_W'(V_ACTIVE - BORDER_WIDTH);
  // Clearing the lowest set bit leaves something only when two or more sprites hit
  assign hit_multi = bus.video_active && |(hit & (hit - NUM_SPRITES'(1)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rgb_q <= '0;
      overlap_q <= 1'b0;
      acc <= 1'b0;
    end else begin
      rgb_q <= !bus.video_active ? 6'd0 : border ? 6'b111111 : spr_rgb;
      overlap_q <= bus.frame_tick ? acc : overlap_q;
      acc <= bus.frame_tick ? hit_multi : acc | hit_multi;
    end
  assign bus.rgb = rgb_q;
  assign bus.overlap = overlap_q;
  assign bus.bounce_count = bounce_q;
endmodule
